// File: rtl/output_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : noc_pkg
// Shared defaults, types and helpers for the tree NoC router output ports.
// Rev 1.0 : initial release
// ============================================================================
package noc_pkg;

    localparam int WIDTH_PACKET_DEFAULT = 14;
    localparam int N_IN_DEFAULT         = 3;

    typedef logic [WIDTH_PACKET_DEFAULT-1:0]     packet_t;
    typedef logic [$clog2(N_IN_DEFAULT)-1:0]     port_idx_t;

    // Next port index in round-robin order, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/output_port_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module  : rr_grant
// Rotate-priority encoder: first set request at or after ptr, modulo N.
// Rev 1.0 : initial release
// ============================================================================
module rr_grant
    import noc_pkg::*;
#(
    parameter int N     = N_IN_DEFAULT,
    parameter int IDX_W = $clog2(N_IN_DEFAULT)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] sel;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        sel   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (pos >= N_EXT) begin
                pos = pos - N_EXT;
            end
            sel = pos[IDX_W-1:0];
            if (!any && req[sel]) begin
                any        = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : output_port_arbiter
// Round-robin output-port scheduler with port mask and 2-entry output FIFO.
// Rev 1.0 : initial release
// ============================================================================
module output_port_arbiter
    import noc_pkg::*;
#(
    parameter int              WIDTH_packet = WIDTH_PACKET_DEFAULT,
    parameter int              N_IN         = N_IN_DEFAULT,
    parameter logic [N_IN-1:0] PORT_MASK    = {N_IN{1'b1}},
    parameter int              CNT_W        = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_IN-1:0]              in_valid,
    input  logic [N_IN*WIDTH_packet-1:0] in_data,
    output logic [N_IN-1:0]              in_ready,
    output logic                         out_valid,
    output logic [WIDTH_packet-1:0]      out_data,
    output logic [$clog2(N_IN)-1:0]      out_src,
    input  logic                         out_ready,
    output logic [CNT_W-1:0]             pkt_cnt
);

    localparam int IDX_W = $clog2(N_IN);

    logic [WIDTH_packet-1:0] in_pkt [N_IN];
    logic [N_IN-1:0]         elig;
    logic [N_IN-1:0]         grant_oh;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_any;
    logic                    space;
    logic                    accept;
    logic                    pop;

    logic [IDX_W-1:0]        rr_ptr;
    logic [1:0]              count;
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [WIDTH_packet-1:0] fifo_data [2];
    logic [IDX_W-1:0]        fifo_src  [2];

    for (genvar i = 0; i < N_IN; i++) begin : g_unpack
        assign in_pkt[i] = in_data[i*WIDTH_packet +: WIDTH_packet];
    end

    assign elig = in_valid & PORT_MASK;
    // Space depends only on the registered count, so out_ready never reaches in_ready.
    assign space = (count < 2'd2);

    rr_grant #(
        .N     (N_IN),
        .IDX_W (IDX_W)
    ) u_rr_grant (
        .req   (elig),
        .ptr   (rr_ptr),
        .grant (grant_oh),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign accept   = rst_n && space && grant_any;
    assign in_ready = accept ? grant_oh : '0;

    assign out_valid = (count != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_src   = fifo_src[rd_ptr];
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            pkt_cnt <= '0;
            for (int e = 0; e < 2; e++) begin
                fifo_data[e] <= '0;
                fifo_src[e]  <= '0;
            end
        end else begin
            if (accept) begin
                fifo_data[wr_ptr] <= in_pkt[grant_idx];
                fifo_src[wr_ptr]  <= grant_idx;
                wr_ptr            <= ~wr_ptr;
                rr_ptr            <= IDX_W'(wrap_inc(int'(grant_idx), N_IN));
                pkt_cnt           <= pkt_cnt + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_output_port_arbiter
// Directed self-checking bench: default instance plus a masked/narrow-counter one.
// Rev 1.0 : initial release
// ============================================================================
module tb_output_port_arbiter;

    localparam int W = 14;

    logic          clk = 1'b0;
    logic          rst_n;

    logic [2:0]    in_valid;
    logic [3*W-1:0] in_data;
    logic [2:0]    in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [1:0]    out_src;
    logic          out_ready;
    logic [15:0]   pkt_cnt;

    logic [2:0]    b_in_valid;
    logic [3*W-1:0] b_in_data;
    logic [2:0]    b_in_ready;
    logic          b_out_valid;
    logic [W-1:0]  b_out_data;
    logic [1:0]    b_out_src;
    logic          b_out_ready;
    logic [3:0]    b_pkt_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    output_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .pkt_cnt   (pkt_cnt)
    );

    output_port_arbiter #(
        .PORT_MASK (3'b101),
        .CNT_W     (4)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_src   (b_out_src),
        .out_ready (b_out_ready),
        .pkt_cnt   (b_pkt_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [W-1:0] seq [3];
        logic [W-1:0] exp_data;
        int           s;

        rst_n       = 1'b0;
        in_valid    = 3'b111;
        in_data     = {14'h0A2, 14'h0A1, 14'h0A0};
        out_ready   = 1'b1;
        b_in_valid  = 3'b000;
        b_in_data   = '0;
        b_out_ready = 1'b1;

        // Reset held with all inputs requesting
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_in_ready", 32'(in_ready), 32'h0);
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_pkt_cnt", 32'(pkt_cnt), 32'h0);
        end
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_src", 32'(out_src), 32'h0);

        // All requesting, full throughput
        rst_n = 1'b1;
        #1;
        chk("first_grant", 32'(in_ready), 32'h1);
        for (int k = 0; k < 6; k++) begin
            chk("rr_in_ready", 32'(in_ready), 32'(1 << (k % 3)));
            tick();
            chk("rr_out_valid", 32'(out_valid), 32'h1);
            chk("rr_out_src", 32'(out_src), 32'(k % 3));
            chk("rr_out_data", 32'(out_data), 32'(14'h0A0 + k % 3));
            chk("rr_pkt_cnt", 32'(pkt_cnt), 32'(k + 1));
        end

        // Drain the remaining head
        in_valid = 3'b000;
        tick();
        chk("drain_out_valid", 32'(out_valid), 32'h0);
        chk("drain_pkt_cnt", 32'(pkt_cnt), 32'd6);

        // Back-pressure with inputs 0 and 1
        in_valid  = 3'b011;
        out_ready = 1'b0;
        #1;
        chk("bp_grant0", 32'(in_ready), 32'h1);
        tick();
        chk("bp_head_src", 32'(out_src), 32'h0);
        in_valid = 3'b010;
        #1;
        chk("bp_grant1", 32'(in_ready), 32'h2);
        tick();
        in_valid = 3'b011;
        in_data  = {14'h0A2, 14'h0A1, 14'h0B0};
        #1;
        chk("bp_full_ready", 32'(in_ready), 32'h0);
        chk("bp_head_data", 32'(out_data), 32'h0A0);
        chk("bp_pkt_cnt", 32'(pkt_cnt), 32'd8);
        tick();
        chk("bp_hold_data", 32'(out_data), 32'h0A0);
        chk("bp_hold_src", 32'(out_src), 32'h0);
        chk("bp_hold_ready", 32'(in_ready), 32'h0);

        in_valid  = 3'b000;
        out_ready = 1'b1;
        tick();
        chk("bp_pop1_valid", 32'(out_valid), 32'h1);
        chk("bp_pop1_data", 32'(out_data), 32'h0A1);
        chk("bp_pop1_src", 32'(out_src), 32'h1);
        tick();
        chk("bp_pop2_valid", 32'(out_valid), 32'h0);
        chk("bp_pop2_cnt", 32'(pkt_cnt), 32'd8);

        // Fill FIFO, then reset mid-flight
        in_data   = {14'h0A2, 14'h0A1, 14'h0A0};
        in_valid  = 3'b111;
        out_ready = 1'b0;
        #1;
        chk("mf_grant2", 32'(in_ready), 32'h4);
        tick();
        in_valid = 3'b011;
        #1;
        chk("mf_grant0", 32'(in_ready), 32'h1);
        tick();
        chk("mf_full_ready", 32'(in_ready), 32'h0);
        chk("mf_pkt_cnt", 32'(pkt_cnt), 32'd10);
        rst_n = 1'b0;
        #1;
        chk("mf_rst_ready", 32'(in_ready), 32'h0);
        tick();
        chk("mf_out_valid", 32'(out_valid), 32'h0);
        chk("mf_cnt_clear", 32'(pkt_cnt), 32'h0);
        chk("mf_out_data", 32'(out_data), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("mf_rr_ptr0", 32'(in_ready), 32'h1);
        in_valid = 3'b000;
        tick();

        // Masked instance: grants alternate 0,2 and the counter wraps
        for (int j = 0; j < 3; j++) begin
            seq[j] = W'(j << 8);
            b_in_data[j*W +: W] = seq[j];
        end
        b_in_valid = 3'b111;
        for (int k = 0; k < 17; k++) begin
            s = (k % 2 == 0) ? 0 : 2;
            #1;
            chk("mask_in_ready", 32'(b_in_ready), 32'(1 << s));
            exp_data = seq[s];
            tick();
            chk("mask_out_src", 32'(b_out_src), 32'(s));
            chk("mask_out_data", 32'(b_out_data), 32'(exp_data));
            chk("mask_pkt_cnt", 32'(b_pkt_cnt), 32'((k + 1) % 16));
            seq[s] = seq[s] + W'(1);
            b_in_data[s*W +: W] = seq[s];
        end
        chk("wrap_pkt_cnt", 32'(b_pkt_cnt), 32'h1);
        chk("idle_a_cnt", 32'(pkt_cnt), 32'h0);

        b_in_valid = 3'b000;
        tick();
        chk("mask_drain", 32'(b_out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
